store_align_buffer: RTL

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

---
 rtl/store_align_buffer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/store_align_buffer.sv
// -----------------------------------------------------------------------------
// store_align_buffer
//
// Buffers store requests in a small FIFO and turns each one into one or two
// lane-aligned bus write beats. The byte offset inside the bus word shifts
// both the data and the byte enables. An access that runs past the end of the
// bus word is split into a second beat at the next aligned address.
//
// Optional feature macro: MISALIGN_SPLIT_EN
//   defined   : any legal size at any offset is accepted, lane-shifted and,
//               when it crosses the bus word, split into two beats.
//   undefined : a request whose address is not a multiple of its size is
//               accepted but dropped, and misalign_err pulses.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid/ready     store request handshake
//   req_addr            byte address
//   req_size            00 byte, 01 half, 10 word, 11 dword (64-bit bus only)
//   req_wdata           right-justified store data
//   bus_valid/ready     bus beat handshake
//   bus_addr            beat address, aligned to DATA_W/8
//   bus_byteen          lane enables
//   bus_wdata           lane-aligned beat data
//   misalign_err        one-cycle pulse, cycle after a dropped request
//   count               FIFO occupancy (excludes the beat in the output regs)
//   dbg_state           output FSM state (0 IDLE, 1 FIRST, 2 SECOND)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The sender holds valid and payload until that edge. req_ready
// depends only on reset_n and count, never on req_valid. The bus payload
// never changes while bus_valid is high and bus_ready is low.
// -----------------------------------------------------------------------------
module store_align_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [31:0]              bus_addr,
  output logic [DATA_W/8-1:0]      bus_byteen,
  output logic [DATA_W-1:0]        bus_wdata,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t state;
  logic   split_q;   // beat on the bus is the first half of a split access

  // FIFO storage
  logic [31:0]       mem_addr  [DEPTH];
  logic [1:0]        mem_size  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // ---------------------------------------------------------------------------
  // Request classification
  // ---------------------------------------------------------------------------
  logic accept;
  logic illegal;
  logic misaligned;
  logic drop;
  logic push;

  assign req_ready = reset_n && (count < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign illegal   = (DATA_W == 32) && (req_size == 2'b11);

`ifdef MISALIGN_SPLIT_EN
  assign misaligned = 1'b0;
`else
  logic [2:0] align_mask;
  always_comb begin
    align_mask = 3'b000;
    case (req_size)
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end
  assign misaligned = (req_addr[2:0] & align_mask) != 3'b000;
`endif

  assign drop = illegal || misaligned;
  assign push = accept && !drop;

  // ---------------------------------------------------------------------------
  // Head selection: an empty FIFO forwards the incoming request so that a
  // request accepted in cycle N is on the bus in cycle N+1. The entry is
  // still written to the FIFO; if it is popped the same cycle, count stays.
  // ---------------------------------------------------------------------------
  logic              fifo_empty;
  logic              avail;
  logic [31:0]       head_addr;
  logic [1:0]        head_size;
  logic [DATA_W-1:0] head_wdata;

  assign fifo_empty = (count == '0);
  assign avail      = !fifo_empty || push;

  always_comb begin
    if (fifo_empty) begin
      head_addr  = req_addr;
      head_size  = req_size;
      head_wdata = req_wdata;
    end else begin
      head_addr  = mem_addr[rd_ptr];
      head_size  = mem_size[rd_ptr];
      head_wdata = mem_wdata[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Lane alignment. The mask and data are built at double width: the low half
  // is the first beat and the high half is exactly the second beat.
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]    off;
  logic [3:0]          nbytes;
  logic [4:0]          span;
  logic [2*BYTES-1:0]  one_mask;
  logic [2*BYTES-1:0]  lane_mask;
  logic [2*DATA_W-1:0] lane_data;
  logic [31:0]         base_addr;
  logic                head_split;

  always_comb begin
    off        = head_addr[OFF_W-1:0];
    nbytes     = 4'd1 << head_size;
    span       = 5'(off) + 5'(nbytes);
    head_split = span > 5'(BYTES);
    one_mask   = {{(2*BYTES-1){1'b0}}, 1'b1};
    lane_mask  = ((one_mask << nbytes) - one_mask) << off;
    lane_data  = {{DATA_W{1'b0}}, head_wdata} << {off, 3'b000};
    base_addr  = {head_addr[31:OFF_W], {OFF_W{1'b0}}};
  end

  // ---------------------------------------------------------------------------
  // Output sequencing
  // ---------------------------------------------------------------------------
  logic load_first;
  logic load_second;
  logic pop;

  always_comb begin
    load_first  = 1'b0;
    load_second = 1'b0;
    case (state)
      IDLE:    load_first = avail;
      FIRST: begin
        if (bus_ready) begin
          if (split_q) load_second = 1'b1;
          else         load_first  = avail;
        end
      end
      SECOND:  if (bus_ready) load_first = avail;
      default: ;
    endcase
  end

  // A split entry stays at the head until its second beat is loaded.
  assign pop = (load_first && !head_split) || load_second;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= req_addr;
      mem_size[wr_ptr]  <= req_size;
      mem_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      split_q      <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus_valid    <= 1'b0;
      bus_addr     <= '0;
      bus_byteen   <= '0;
      bus_wdata    <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && drop;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (load_first) begin
        state      <= FIRST;
        split_q    <= head_split;
        bus_valid  <= 1'b1;
        bus_addr   <= base_addr;
        bus_byteen <= lane_mask[BYTES-1:0];
        bus_wdata  <= lane_data[DATA_W-1:0];
      end else if (load_second) begin
        state      <= SECOND;
        split_q    <= 1'b0;
        bus_valid  <= 1'b1;
        bus_addr   <= base_addr + 32'(BYTES);
        bus_byteen <= lane_mask[2*BYTES-1:BYTES];
        bus_wdata  <= lane_data[2*DATA_W-1:DATA_W];
      end else if (state != IDLE && bus_ready) begin
        state     <= IDLE;
        split_q   <= 1'b0;
        bus_valid <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule
